// File: rtl/slice_counter_arbiter_pkg.sv
// Shared constants for the time-slice arbiter: FSM encoding, counter width
// and the codes that record why a slice ended.
package slice_counter_arbiter_pkg;

   localparam int CNT_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_HANDOFF = 2'd2;

   localparam logic [1:0] CAUSE_NONE   = 2'd0;
   localparam logic [1:0] CAUSE_REL    = 2'd1;
   localparam logic [1:0] CAUSE_DROP   = 2'd2;
   localparam logic [1:0] CAUSE_EXPIRE = 2'd3;

endpackage

// File: rtl/slice_counter_arbiter_if.sv
// Bundle between requesting clients, the shared 4-bit counter and the arbiter.
interface slice_counter_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
);
   import slice_counter_arbiter_pkg::*;

   // Handshake: REQ is a level held by a client for as long as it wants the
   // counter; GNT is the one-hot answer and stays high while that client owns
   // the slice. A grant ends when the owner pulses REL, drops REQ, or the
   // quantum runs out; GNT then goes low for at least one cycle.
   logic [N_REQ-1:0] REQ;
   logic [N_REQ-1:0] REL;
   logic [CNT_W-1:0] SLICE_LEN;
   logic [CNT_W-1:0] CNT_Q;
   logic             CNT_EN;
   logic             CNT_CLR;
   logic [N_REQ-1:0] GNT;
   logic             GNT_VLD;
   logic [IDW-1:0]   GNT_ID;
   logic             EXPIRE;
   logic             ERR;
   logic [1:0]       STATE;

   modport master (
      output REQ, REL, SLICE_LEN, CNT_Q,
      input  CNT_EN, CNT_CLR, GNT, GNT_VLD, GNT_ID, EXPIRE, ERR, STATE
   );

   modport slave (
      input  REQ, REL, SLICE_LEN, CNT_Q,
      output CNT_EN, CNT_CLR, GNT, GNT_VLD, GNT_ID, EXPIRE, ERR, STATE
   );

endinterface

// File: rtl/slice_counter_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or above the pointer,
// wrapping from N_REQ-1 back to 0.
module slice_counter_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   win,
   output logic             any
);

   always_comb begin
      win = '0;
      any = 1'b0;
      // Walk offsets from the far end so the closest request is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N_REQ]) begin
            win = IDW'((int'(ptr) + i) % N_REQ);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/slice_counter_arbiter.sv
// Time-slice arbiter sharing one external 4-bit counter between N_REQ clients,
// with a shadow count that flags any disagreement with the counter output.
module slice_counter_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   slice_counter_arbiter_if.slave bus
);
   import slice_counter_arbiter_pkg::*;

   logic [1:0]       state;
   logic [N_REQ-1:0] gnt;
   logic             gnt_vld;
   logic [IDW-1:0]   owner;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   next_ptr;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] shadow;
   logic             expire;
   logic             err;
   logic [1:0]       cause;
   logic [IDW-1:0]   win;
   logic             any;
   logic [N_REQ-1:0] win_onehot;

   slice_counter_arbiter_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
      .req (bus.REQ),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win;
   assign next_ptr   = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

   // Release outranks expiry, so a coincident REL/drop never pulses EXPIRE.
   always_comb begin
      cause = CAUSE_NONE;
      if (bus.REL[owner])       cause = CAUSE_REL;
      else if (!bus.REQ[owner]) cause = CAUSE_DROP;
      else if (shadow == len_q) cause = CAUSE_EXPIRE;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         owner   <= '0;
         ptr     <= '0;
         len_q   <= '0;
         shadow  <= '0;
         expire  <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state)
            ST_GRANT: begin
               shadow <= shadow + 1'b1;
               if (bus.CNT_Q != shadow) err <= 1'b1;
               if (cause != CAUSE_NONE) begin
                  state   <= ST_HANDOFF;
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  ptr     <= next_ptr;
                  shadow  <= '0;
                  expire  <= (cause == CAUSE_EXPIRE);
               end
            end
            ST_IDLE, ST_HANDOFF: begin
               expire <= 1'b0;
               if (any) begin
                  state   <= ST_GRANT;
                  gnt     <= win_onehot;
                  gnt_vld <= 1'b1;
                  owner   <= win;
                  len_q   <= bus.SLICE_LEN;
                  shadow  <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Counter runs only while a grant is live; outside it, clear is held.
   assign bus.CNT_EN  = (state == ST_GRANT);
   assign bus.CNT_CLR = (state == ST_GRANT);
   assign bus.GNT     = gnt;
   assign bus.GNT_VLD = gnt_vld;
   assign bus.GNT_ID  = owner;
   assign bus.EXPIRE  = expire;
   assign bus.ERR     = err;
   assign bus.STATE   = state;

endmodule

// File: tb/tb_slice_counter_arbiter.sv
// Directed bench for slice_counter_arbiter with a behavioural model of the
// shared 4-bit counter (sync active-low clear) and an optional stuck-at-0 fault.
module tb_slice_counter_arbiter;
   import slice_counter_arbiter_pkg::*;

   logic CLK;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   slice_counter_arbiter_if #(.N_REQ(4), .IDW(2)) bus ();

   slice_counter_arbiter #(.N_REQ(4), .IDW(2)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [3:0] cnt;
   bit         stuck;
   always @(posedge CLK) begin
      if (!bus.CNT_CLR)    cnt <= 4'd0;
      else if (bus.CNT_EN) cnt <= cnt + 4'd1;
   end
   assign bus.CNT_Q = stuck ? 4'd0 : cnt;

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      bus.REQ = '0;
      bus.REL = '0;
      stuck   = 1'b0;
      RST     = 1'b0;
      step();
      step();
      RST = 1'b1;
   endtask

   task automatic wait_vld(output bit tmo);
      int n = 0;
      while (!bus.GNT_VLD && n < 50) begin
         step();
         n++;
      end
      tmo = !bus.GNT_VLD;
   endtask

   // Follows one grant from the current negedge: cycles waited, grant vector,
   // grant length, and EXPIRE in the first cycle after it.
   task automatic measure_grant(output logic [3:0] g, output int len,
                                output int gap, output logic exp_seen);
      gap = 0;
      while (!bus.GNT_VLD && gap < 50) begin
         step();
         gap++;
      end
      g   = bus.GNT;
      len = 0;
      while (bus.GNT_VLD && bus.GNT == g && len < 40) begin
         len++;
         step();
      end
      exp_seen = bus.EXPIRE;
   endtask

   task automatic test_reset();
      bus.REQ = '0; bus.REL = '0; bus.SLICE_LEN = 4'd0; stuck = 1'b0;
      cnt = 4'd0;
      RST = 1'b0;
      step();
      step();
      checks++; if (bus.GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.GNT); end
      checks++; if (bus.GNT_VLD !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.GNT_VLD); end
      checks++; if (bus.GNT_ID !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.GNT_ID); end
      checks++; if (bus.CNT_EN !== 1'b0 || bus.CNT_CLR !== 1'b0) begin errors++; $display("FAIL reset_cnt_ctl: got en=%b clr=%b expected en=0 clr=0", bus.CNT_EN, bus.CNT_CLR); end
      checks++; if (bus.EXPIRE !== 1'b0 || bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_flags: got expire=%b err=%b expected 0 0", bus.EXPIRE, bus.ERR); end
      checks++; if (bus.STATE !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.STATE, ST_IDLE); end
      RST = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0] g; int len; int gap; logic ex;
      bus.SLICE_LEN = 4'd3;
      bus.REQ       = 4'b0001;
      measure_grant(g, len, gap, ex);
      checks++; if (g !== 4'b0001 || len != 4 || gap != 1) begin errors++; $display("FAIL single_grant: got gnt=%b len=%0d gap=%0d expected 0001 4 1", g, len, gap); end
      checks++; if (ex !== 1'b1) begin errors++; $display("FAIL single_expire: got %b expected 1", ex); end
      checks++; if (bus.GNT_ID !== 2'd0 || bus.CNT_CLR !== 1'b0) begin errors++; $display("FAIL single_handoff: got id=%0d clr=%b expected 0 0", bus.GNT_ID, bus.CNT_CLR); end
      measure_grant(g, len, gap, ex);
      checks++; if (g !== 4'b0001 || gap != 1) begin errors++; $display("FAIL single_regrant: got gnt=%b gap=%0d expected 0001 1", g, gap); end
      bus.REQ = '0;
      step();
      checks++; if (bus.STATE !== ST_IDLE) begin errors++; $display("FAIL single_idle: got %0d expected %0d", bus.STATE, ST_IDLE); end
   endtask

   task automatic test_rotate();
      logic [3:0] exp_g [5];
      logic [3:0] g; int len; int gap; logic ex;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset();
      bus.SLICE_LEN = 4'd2;
      bus.REQ       = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         measure_grant(g, len, gap, ex);
         checks++; if (g !== exp_g[k] || len != 3 || gap != 1 || ex !== 1'b1) begin errors++; $display("FAIL rotate_%0d: got gnt=%b len=%0d gap=%0d exp=%b expected %b 3 1 1", k, g, len, gap, ex, exp_g[k]); end
         if (k == 3) begin
            checks++; if (bus.GNT_ID !== 2'd3) begin errors++; $display("FAIL rotate_id_hold: got %0d expected 3", bus.GNT_ID); end
         end
      end
      checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL rotate_err: got %b expected 0", bus.ERR); end
      bus.REQ = '0;
      step();
   endtask

   task automatic test_release();
      bit tmo;
      apply_reset();
      bus.SLICE_LEN = 4'd7;
      bus.REQ       = 4'b0011;
      wait_vld(tmo);
      checks++; if (tmo || bus.GNT !== 4'b0001 || bus.CNT_Q !== 4'd0) begin errors++; $display("FAIL rel_first: got gnt=%b q=%0d tmo=%b expected 0001 0 0", bus.GNT, bus.CNT_Q, tmo); end
      step();
      checks++; if (bus.CNT_Q !== 4'd1) begin errors++; $display("FAIL rel_q1: got %0d expected 1", bus.CNT_Q); end
      bus.REL       = 4'b0001;
      bus.SLICE_LEN = 4'd1;
      step();
      checks++; if (bus.GNT_VLD !== 1'b0 || bus.EXPIRE !== 1'b0) begin errors++; $display("FAIL rel_handoff: got vld=%b expire=%b expected 0 0", bus.GNT_VLD, bus.EXPIRE); end
      bus.REL = '0;
      step();
      checks++; if (bus.GNT !== 4'b0010 || bus.GNT_ID !== 2'd1) begin errors++; $display("FAIL rel_next: got gnt=%b id=%0d expected 0010 1", bus.GNT, bus.GNT_ID); end
      step();
      bus.REL = 4'b0010;
      step();
      checks++; if (bus.GNT_VLD !== 1'b0 || bus.EXPIRE !== 1'b0) begin errors++; $display("FAIL rel_at_expiry: got vld=%b expire=%b expected 0 0", bus.GNT_VLD, bus.EXPIRE); end
      bus.REL = '0;
      bus.REQ = '0;
      step();
   endtask

   task automatic test_drop_and_len();
      bit tmo; int n; logic [3:0] last_q;
      apply_reset();
      bus.SLICE_LEN = 4'd5;
      bus.REQ       = 4'b0001;
      wait_vld(tmo);
      n = 0; last_q = 4'd0;
      while (bus.GNT_VLD && n < 40) begin
         if (n == 1) bus.SLICE_LEN = 4'd1;
         last_q = bus.CNT_Q;
         n++;
         step();
      end
      checks++; if (tmo || n != 6 || last_q !== 4'd5 || bus.EXPIRE !== 1'b1) begin errors++; $display("FAIL len_change: got len=%0d last_q=%0d expire=%b tmo=%b expected 6 5 1 0", n, last_q, bus.EXPIRE, tmo); end
      bus.SLICE_LEN = 4'd9;
      wait_vld(tmo);
      step();
      step();
      bus.REQ = '0;
      step();
      checks++; if (tmo || bus.GNT_VLD !== 1'b0 || bus.EXPIRE !== 1'b0 || bus.STATE !== ST_HANDOFF) begin errors++; $display("FAIL drop_handoff: got vld=%b expire=%b state=%0d expected 0 0 %0d", bus.GNT_VLD, bus.EXPIRE, bus.STATE, ST_HANDOFF); end
      step();
      checks++; if (bus.STATE !== ST_IDLE) begin errors++; $display("FAIL drop_idle: got %0d expected %0d", bus.STATE, ST_IDLE); end
   endtask

   task automatic test_stuck_counter();
      bit tmo; logic [3:0] g; int len; int gap; logic ex;
      apply_reset();
      bus.SLICE_LEN = 4'd3;
      bus.REQ       = 4'b0001;
      wait_vld(tmo);
      stuck = 1'b1;
      step();
      step();
      checks++; if (tmo || bus.ERR !== 1'b1) begin errors++; $display("FAIL stuck_err: got %b expected 1", bus.ERR); end
      stuck = 1'b0;
      measure_grant(g, len, gap, ex);
      measure_grant(g, len, gap, ex);
      checks++; if (g !== 4'b0001 || len != 4 || bus.ERR !== 1'b1) begin errors++; $display("FAIL stuck_sticky: got gnt=%b len=%0d err=%b expected 0001 4 1", g, len, bus.ERR); end
      apply_reset();
      checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b expected 0", bus.ERR); end
   endtask

   task automatic test_async_reset();
      logic [3:0] g; int len; int gap; logic ex; bit tmo;
      apply_reset();
      bus.SLICE_LEN = 4'd4;
      bus.REQ       = 4'b0100;
      measure_grant(g, len, gap, ex);
      wait_vld(tmo);
      step();
      #2 RST = 1'b0;
      #1;
      checks++; if (tmo || bus.GNT !== 4'b0000 || bus.GNT_VLD !== 1'b0 || bus.CNT_EN !== 1'b0 || bus.CNT_CLR !== 1'b0) begin errors++; $display("FAIL async_abort: got gnt=%b vld=%b en=%b clr=%b expected 0000 0 0 0", bus.GNT, bus.GNT_VLD, bus.CNT_EN, bus.CNT_CLR); end
      step();
      bus.REQ = 4'b1100;
      RST     = 1'b1;
      wait_vld(tmo);
      checks++; if (tmo || bus.GNT !== 4'b0100) begin errors++; $display("FAIL async_ptr_reset: got %b expected 0100", bus.GNT); end
      bus.REQ = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_release();
      test_drop_and_len();
      test_stuck_counter();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
